// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. It owns the PC and issues word requests
// to instruction memory. A credit count caps in-flight plus buffered words at
// FIFO_DEPTH, so a response always finds a free FIFO slot. Words are presented
// to decode over valid/ready. A redirect flushes the FIFO and discards responses
// that are still in flight.
// Optional macro FETCH_STATS_EN adds the FetchCnt / DropCnt statistic outputs.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic        ImemRvalid,
  input  logic [31:0] ImemRdata,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] Instruction,
  output logic [31:0] InstrPC
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] FetchCnt,
  output logic [31:0] DropCnt
`endif
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;   // PC belonging to the next kept response
  logic [CW-1:0] pend_q, pend_d;         // accepted requests awaiting a response
  logic [CW-1:0] drop_q, drop_d;         // pending responses still to be discarded
  logic [CW-1:0] cnt_q, cnt_d;           // FIFO occupancy
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]   fifo_instr_q [FIFO_DEPTH];

  logic          accept;
  logic          pop;
  logic          push;
  logic          discard;
  logic [CW:0]   in_use;
  logic [31:0]   redirect_pc;
  logic          unused_redirect_lsbs;

  assign redirect_pc          = {RedirectPC[31:2], 2'b00};
  assign unused_redirect_lsbs = ^RedirectPC[1:0];

  // Handshakes and outputs. A pop in this cycle frees a credit immediately,
  // which is what sustains one word per cycle with a two-entry FIFO at L=1.
  // A request raised on that credit stays legal next cycle because the pop has
  // already lowered the occupancy, so ImemAddr/ImemReq stay stable until accepted.
  always_comb begin
    in_use      = (CW+1)'(pend_q) + (CW+1)'(cnt_q);
    InstrValid  = (cnt_q != '0) && !Redirect;
    pop         = InstrValid && InstrReady;
    ImemReq     = Reset_n && !Redirect && ((in_use < (CW+1)'(FIFO_DEPTH)) || pop);
    ImemAddr    = pc_q;
    accept      = ImemReq && ImemReady;
    discard     = ImemRvalid && (Redirect || (drop_q != '0));
    push        = ImemRvalid && !discard;
    Instruction = InstrValid ? fifo_instr_q[rd_ptr_q] : 32'h0;
    InstrPC     = InstrValid ? fifo_pc_q[rd_ptr_q]    : 32'h0;
  end

  // Next-state logic for the PC, the credit counters and the FIFO pointers.
  // NOTE: every variable gets its hold value first, so no path can infer a latch.
  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    drop_d    = drop_q;
    cnt_d     = cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pend_d    = pend_q + CW'(accept) - CW'(ImemRvalid);
    if (Redirect) begin
      pc_d      = redirect_pc;
      resp_pc_d = redirect_pc;
      drop_d    = pend_q - CW'(ImemRvalid);
      cnt_d     = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
    end else begin
      if (accept) pc_d = pc_q + 32'd4;
      if (ImemRvalid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Control state register with asynchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      pend_q    <= '0;
      drop_q    <= '0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      pend_q    <= pend_d;
      drop_q    <= drop_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // FIFO storage: write the kept response together with its PC.
  // NOTE: the storage array has no reset; cnt_q alone decides which entries are valid.
  always_ff @(posedge Clk) begin
    if (push && !Redirect) begin
      fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
      fifo_instr_q[wr_ptr_q] <= ImemRdata;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] drop_cnt_q;

  // Statistics counters: words delivered to decode and responses thrown away.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (pop)     fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (discard) drop_cnt_q  <= drop_cnt_q + 32'd1;
    end
  end

  assign FetchCnt = fetch_cnt_q;
  assign DropCnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic for fetch_unit.
// A latency-L memory model answers requests. A queue-based reference model
// predicts the fetch address stream, the buffered words, drops and handshakes.
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        Clk;
  logic        Reset_n;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemReady;
  logic        ImemRvalid;
  logic [31:0] ImemRdata;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instruction;
  logic [31:0] InstrPC;
`ifdef FETCH_STATS_EN
  logic [31:0] FetchCnt;
  logic [31:0] DropCnt;
`endif

  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .ImemReq     (ImemReq),
    .ImemAddr    (ImemAddr),
    .ImemReady   (ImemReady),
    .ImemRvalid  (ImemRvalid),
    .ImemRdata   (ImemRdata),
    .Redirect    (Redirect),
    .RedirectPC  (RedirectPC),
    .InstrValid  (InstrValid),
    .InstrReady  (InstrReady),
    .Instruction (Instruction),
    .InstrPC     (InstrPC)
`ifdef FETCH_STATS_EN
    ,
    .FetchCnt    (FetchCnt),
    .DropCnt     (DropCnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct { logic [31:0] pc; bit keep; }            flight_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; }  entry_t;
  typedef struct { logic [31:0] addr; int due; }           mreq_t;

  flight_t     inflight[$];   // model: accepted, not yet answered
  entry_t      fifo_m[$];     // model: buffered words
  mreq_t       mem_q[$];      // memory: outstanding requests
  logic [31:0] acc_log[$];    // observed accepted addresses
  logic [31:0] pop_log[$];    // observed consumed InstrPC values
  logic [31:0] exp_fetch_pc;
  int          exp_fetches;
  int          exp_drops;
  int          cyc;
  int          lat;
  int          n_checks;
  int          n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic model_clear();
    inflight.delete();
    fifo_m.delete();
    mem_q.delete();
    acc_log.delete();
    pop_log.delete();
    exp_fetch_pc = RST_PC;
    exp_fetches  = 0;
    exp_drops    = 0;
  endtask

  // Holds reset for two edges, checks reset outputs, and releases just after an edge.
  task automatic do_reset();
    Reset_n    = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = 32'h0;
    ImemReady  = 1'b0;
    InstrReady = 1'b0;
    ImemRvalid = 1'b0;
    ImemRdata  = 32'h0;
    model_clear();
    @(negedge Clk);
    check("rst_req",   {31'h0, ImemReq},    32'h0);
    check("rst_addr",  ImemAddr,            RST_PC);
    check("rst_valid", {31'h0, InstrValid}, 32'h0);
    check("rst_instr", Instruction,         32'h0);
    check("rst_pc",    InstrPC,             32'h0);
`ifdef FETCH_STATS_EN
    check("rst_fcnt",  FetchCnt,            32'h0);
    check("rst_dcnt",  DropCnt,             32'h0);
`endif
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    cyc = 0;
  endtask

  // One clock cycle: drive inputs, check against the model at the falling edge,
  // then advance the model and the memory by the handshakes that will occur.
  task automatic run_cycle(input bit imem_ready, input bit instr_ready,
                           input bit redir, input logic [31:0] redir_pc);
    bit          exp_valid;
    bit          exp_pop;
    bit          exp_req;
    flight_t     f;
    entry_t      e;
    ImemReady  = imem_ready;
    InstrReady = instr_ready;
    Redirect   = redir;
    RedirectPC = redir_pc;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      ImemRvalid = 1'b1;
      ImemRdata  = mem_word(mem_q[0].addr);
    end else begin
      ImemRvalid = 1'b0;
      ImemRdata  = $urandom;
    end
    @(negedge Clk);
    exp_valid = (fifo_m.size() != 0) && !redir;
    exp_pop   = exp_valid && instr_ready;
    exp_req   = !redir && (((inflight.size() + fifo_m.size()) < DEPTH) || exp_pop);
    check("valid", {31'h0, InstrValid}, {31'h0, exp_valid});
    if (exp_valid) begin
      check("instr_pc", InstrPC,     fifo_m[0].pc);
      check("instr",    Instruction, fifo_m[0].instr);
    end else begin
      check("idle_pc",    InstrPC,     32'h0);
      check("idle_instr", Instruction, 32'h0);
    end
    check("req",  {31'h0, ImemReq}, {31'h0, exp_req});
    check("addr", ImemAddr, exp_fetch_pc);
`ifdef FETCH_STATS_EN
    check("fetch_cnt", FetchCnt, exp_fetches);
    check("drop_cnt",  DropCnt,  exp_drops);
`endif
    if (InstrValid && InstrReady) pop_log.push_back(InstrPC);
    if (exp_pop) begin
      void'(fifo_m.pop_front());
      exp_fetches++;
    end
    if (ImemRvalid) begin
      void'(mem_q.pop_front());
      f = inflight.pop_front();
      if (redir || !f.keep) begin
        exp_drops++;
      end else begin
        e.pc    = f.pc;
        e.instr = mem_word(f.pc);
        fifo_m.push_back(e);
        check("no_overflow", {31'h0, (fifo_m.size() <= DEPTH)}, 32'h1);
      end
    end
    if (redir) begin
      foreach (inflight[i]) inflight[i].keep = 1'b0;
      fifo_m.delete();
      exp_fetch_pc = {redir_pc[31:2], 2'b00};
    end
    if (ImemReq && imem_ready) begin
      mem_q.push_back('{addr: ImemAddr, due: cyc + lat});
      inflight.push_back('{pc: exp_fetch_pc, keep: 1'b1});
      acc_log.push_back(ImemAddr);
      exp_fetch_pc = exp_fetch_pc + 32'd4;
    end
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    bit          prev_redir;
    bit          rd;
    logic [31:0] tgt;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    lat      = 1;
    Reset_n  = 1'b1;
    #1;

    // Streaming from reset: L=1, decode always ready.
    do_reset();
    repeat (10) run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("p1_addr0", q_at(acc_log, 0), 32'h0000_3000);
    check("p1_addr1", q_at(acc_log, 1), 32'h0000_3004);
    check("p1_addr2", q_at(acc_log, 2), 32'h0000_3008);
    check("p1_pops",  pop_log.size(),   32'd8);
    check("p1_pop0",  q_at(pop_log, 0), 32'h0000_3000);

    // Decode stalled for 10 cycles: two requests fill the buffer, then stop.
    do_reset();
    repeat (10) run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("p2_accepts", acc_log.size(), 32'd2);
    check("p2_req", {31'h0, ImemReq}, 32'h0);
    check("p2_head", InstrPC, 32'h0000_3000);
    run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("p2_pop0", q_at(pop_log, 0), 32'h0000_3000);

    // L=3: redirect with two requests in flight; both responses are discarded.
    do_reset();
    lat = 3;
    run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    acc_log.delete();
    pop_log.delete();
    run_cycle(1'b1, 1'b0, 1'b1, 32'h0000_4003);
    repeat (10) run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("p3_addr0", q_at(acc_log, 0), 32'h0000_4000);
    check("p3_pop0",  q_at(pop_log, 0), 32'h0000_4000);
`ifdef FETCH_STATS_EN
    check("p3_drops", DropCnt, 32'd2);
`endif

    // Redirect in the same cycle as a response with one request pending.
    do_reset();
    lat = 1;
    run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    acc_log.delete();
    run_cycle(1'b0, 1'b1, 1'b1, 32'h0000_5002);
    repeat (6) run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("p4_addr0", q_at(acc_log, 0), 32'h0000_5000);
    check("p4_pop0",  q_at(pop_log, 0), 32'h0000_5000);
`ifdef FETCH_STATS_EN
    check("p4_drops", DropCnt, 32'd1);
`endif

    // PC wrap after a redirect near the top of the address space.
    do_reset();
    repeat (5) run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    acc_log.delete();
    pop_log.delete();
    run_cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (8) run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("p5_addr0", q_at(acc_log, 0), 32'hFFFF_FFF8);
    check("p5_addr1", q_at(acc_log, 1), 32'hFFFF_FFFC);
    check("p5_addr2", q_at(acc_log, 2), 32'h0000_0000);
    check("p5_pop2",  q_at(pop_log, 2), 32'h0000_0000);

    // Asynchronous reset mid-stream with a full buffer.
    do_reset();
    repeat (4) run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    InstrReady = 1'b1;
    ImemReady  = 1'b1;
    #1;
    check("p6_full_valid", {31'h0, InstrValid}, 32'h1);
    #1 Reset_n = 1'b0;
    #1;
    check("p6_req",   {31'h0, ImemReq},    32'h0);
    check("p6_addr",  ImemAddr,            RST_PC);
    check("p6_valid", {31'h0, InstrValid}, 32'h0);
    check("p6_instr", Instruction,         32'h0);
    check("p6_pc",    InstrPC,             32'h0);
    do_reset();
    run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("p6_first_addr", q_at(acc_log, 0), 32'h0000_3000);

    // Randomized traffic: latency, readiness and redirects drawn per segment.
    for (int seg = 0; seg < 8; seg++) begin
      do_reset();
      lat = $urandom_range(1, 4);
      prev_redir = 1'b0;
      for (int c = 0; c < 300; c++) begin
        rd  = !prev_redir && ($urandom_range(0, 99) < 5);
        tgt = $urandom;
        if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        run_cycle($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 70, rd, tgt);
        prev_redir = rd;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
